// File: rtl/pipe_trace_pkg.sv
// Shared trace types: per-stage slot record, drain FSM states, stage indices.
// Types and constants only; no timing or flow control of its own.
package pipe_trace_pkg;

  // Slot fields are sized for the widest supported build; the top narrows them.
  localparam int ID_MAX_W = 16;
  localparam int PC_MAX_W = 32;

  localparam int NUM_STG = 5;
  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EX  = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB  = 4;

  typedef struct packed {
    logic                valid;
    logic [ID_MAX_W-1:0] id;
    logic [PC_MAX_W-1:0] pc;
  } trace_slot_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } trace_state_t;

  localparam trace_slot_t BUBBLE = '{valid: 1'b0, id: '0, pc: '0};

endpackage

// File: rtl/trace_slot_reg.sv
// One pipeline-stage trace slot; 1-cycle register, async reset to an empty slot.
// Control priority is hold > bubble > load; with nothing asserted the slot keeps its value.
module trace_slot_reg
  import pipe_trace_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_hold,
  input  logic        i_bubble,
  input  logic        i_load,
  input  trace_slot_t i_d,
  output trace_slot_t o_q
);

  trace_slot_t r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= BUBBLE;
    end else if (!i_hold) begin
      if (i_bubble) begin
        r_q <= BUBBLE;
      end else if (i_load) begin
        r_q <= i_d;
      end
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pipeline_trace_tracker.sv
// Instruction trace shadow of the 5-stage CPU pipeline: tags fetches and follows them IF..WB.
// All outputs registered, IF to WB in 4 edges plus stall edges; stall holds IF/ID, no backpressure out.
module pipeline_trace_tracker
  import pipe_trace_pkg::*;
#(
  parameter int ID_W  = 7,
  parameter int PC_W  = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pc_stall,
  input  logic             if_flush,
  input  logic             halt_fetch,
  input  logic [PC_W-1:0]  fetch_pc,
  output logic             if_valid,
  output logic             id_valid,
  output logic             ex_valid,
  output logic             mem_valid,
  output logic             wb_valid,
  output logic [ID_W-1:0]  if_id,
  output logic [ID_W-1:0]  id_id,
  output logic [ID_W-1:0]  ex_id,
  output logic [ID_W-1:0]  mem_id,
  output logic [ID_W-1:0]  wb_id,
  output logic [PC_W-1:0]  wb_pc,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             done
);

  trace_state_t     r_state;
  trace_state_t     w_state_nxt;
  logic [ID_W-1:0]  r_next_id;
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_retired_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  trace_slot_t        w_slot   [NUM_STG];
  trace_slot_t        w_slot_d [NUM_STG];
  logic [NUM_STG-1:0] w_hold;
  logic [NUM_STG-1:0] w_bubble;
  logic [NUM_STG-1:0] w_load;

  logic w_fetch_en;
  logic w_issue;
  logic w_flush_eff;
  logic w_all_empty;
  logic w_done;
  logic w_unused_bits;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // A stall wins over a flush on the same edge, so the flush is simply dropped.
  assign w_flush_eff = if_flush & ~pc_stall;
  assign w_issue     = w_fetch_en & ~pc_stall;
  assign w_all_empty = ~(w_slot[STG_IF].valid  | w_slot[STG_ID].valid | w_slot[STG_EX].valid |
                         w_slot[STG_MEM].valid | w_slot[STG_WB].valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:     if (!pc_stall && halt_fetch && !if_flush) w_state_nxt = DRAIN;
      DRAIN:   if (w_all_empty) w_state_nxt = DONE;
      DONE:    w_state_nxt = DONE;
      default: w_state_nxt = RUN;
    endcase
  end

  // A squashed HLT (flush alongside) is not a halt: fetching continues.
  always_comb begin
    w_fetch_en = 1'b0;
    w_done     = 1'b0;
    case (r_state)
      RUN:     w_fetch_en = ~(halt_fetch & ~if_flush);
      DONE:    w_done = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    w_hold   = '0;
    w_bubble = '0;
    w_load   = '1;

    w_slot_d[STG_IF]  = '{valid: 1'b1, id: ID_MAX_W'(r_next_id), pc: PC_MAX_W'(fetch_pc)};
    w_slot_d[STG_ID]  = w_slot[STG_IF];
    w_slot_d[STG_EX]  = w_slot[STG_ID];
    w_slot_d[STG_MEM] = w_slot[STG_EX];
    w_slot_d[STG_WB]  = w_slot[STG_MEM];

    w_hold[STG_IF]   = pc_stall;
    w_bubble[STG_IF] = ~w_fetch_en;
    w_hold[STG_ID]   = pc_stall;
    w_bubble[STG_ID] = if_flush;
    w_bubble[STG_EX] = pc_stall;
  end

  for (genvar g = 0; g < NUM_STG; g++) begin : g_stage
    trace_slot_reg u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_hold   (w_hold[g]),
      .i_bubble (w_bubble[g]),
      .i_load   (w_load[g]),
      .i_d      (w_slot_d[g]),
      .o_q      (w_slot[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_next_id <= '0;
    end else if (w_issue) begin
      r_next_id <= r_next_id + ID_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle_cnt   <= '0;
      r_retired_cnt <= '0;
      r_stall_cnt   <= '0;
      r_flush_cnt   <= '0;
    end else begin
      r_cycle_cnt <= sat_inc(r_cycle_cnt);
      if (w_slot[STG_WB].valid) r_retired_cnt <= sat_inc(r_retired_cnt);
      if (pc_stall)             r_stall_cnt   <= sat_inc(r_stall_cnt);
      if (w_flush_eff)          r_flush_cnt   <= sat_inc(r_flush_cnt);
    end
  end

  assign if_valid  = w_slot[STG_IF].valid;
  assign id_valid  = w_slot[STG_ID].valid;
  assign ex_valid  = w_slot[STG_EX].valid;
  assign mem_valid = w_slot[STG_MEM].valid;
  assign wb_valid  = w_slot[STG_WB].valid;

  assign if_id  = w_slot[STG_IF].id[ID_W-1:0];
  assign id_id  = w_slot[STG_ID].id[ID_W-1:0];
  assign ex_id  = w_slot[STG_EX].id[ID_W-1:0];
  assign mem_id = w_slot[STG_MEM].id[ID_W-1:0];
  assign wb_id  = w_slot[STG_WB].id[ID_W-1:0];
  assign wb_pc  = w_slot[STG_WB].pc[PC_W-1:0];

  assign cycle_cnt   = r_cycle_cnt;
  assign retired_cnt = r_retired_cnt;
  assign stall_cnt   = r_stall_cnt;
  assign flush_cnt   = r_flush_cnt;
  assign done        = w_done;

  // Upper slot bits beyond ID_W/PC_W are always zero and intentionally not exported.
  assign w_unused_bits = ^{w_slot[STG_IF], w_slot[STG_ID], w_slot[STG_EX],
                           w_slot[STG_MEM], w_slot[STG_WB]};

endmodule

// File: tb/tb_pipeline_trace_tracker.sv
// Bench for pipeline_trace_tracker: directed table, corner sequences and a random run vs. a reference model.
module tb_pipeline_trace_tracker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        pc_stall = 1'b0;
  logic        if_flush = 1'b0;
  logic        halt_fetch = 1'b0;
  logic [15:0] fetch_pc = '0;

  logic        if_valid, id_valid, ex_valid, mem_valid, wb_valid;
  logic [6:0]  if_id, id_id, ex_id, mem_id, wb_id;
  logic [15:0] wb_pc;
  logic [31:0] cycle_cnt, retired_cnt, stall_cnt, flush_cnt;
  logic        done;

  logic        t3_if_valid, t3_id_valid, t3_ex_valid, t3_mem_valid, t3_wb_valid;
  logic [2:0]  t3_if_id, t3_id_id, t3_ex_id, t3_mem_id, t3_wb_id;
  logic [15:0] t3_wb_pc;
  logic [31:0] t3_cycle_cnt, t3_retired_cnt, t3_stall_cnt, t3_flush_cnt;
  logic        t3_done;

  always #5 clk = ~clk;

  pipeline_trace_tracker #(.ID_W(7), .PC_W(16), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .pc_stall(pc_stall), .if_flush(if_flush),
    .halt_fetch(halt_fetch), .fetch_pc(fetch_pc),
    .if_valid(if_valid), .id_valid(id_valid), .ex_valid(ex_valid),
    .mem_valid(mem_valid), .wb_valid(wb_valid),
    .if_id(if_id), .id_id(id_id), .ex_id(ex_id), .mem_id(mem_id), .wb_id(wb_id),
    .wb_pc(wb_pc), .cycle_cnt(cycle_cnt), .retired_cnt(retired_cnt),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .done(done)
  );

  pipeline_trace_tracker #(.ID_W(3), .PC_W(16), .CNT_W(32)) dut3 (
    .clk(clk), .rst_n(rst_n), .pc_stall(pc_stall), .if_flush(if_flush),
    .halt_fetch(halt_fetch), .fetch_pc(fetch_pc),
    .if_valid(t3_if_valid), .id_valid(t3_id_valid), .ex_valid(t3_ex_valid),
    .mem_valid(t3_mem_valid), .wb_valid(t3_wb_valid),
    .if_id(t3_if_id), .id_id(t3_id_id), .ex_id(t3_ex_id), .mem_id(t3_mem_id), .wb_id(t3_wb_id),
    .wb_pc(t3_wb_pc), .cycle_cnt(t3_cycle_cnt), .retired_cnt(t3_retired_cnt),
    .stall_cnt(t3_stall_cnt), .flush_cnt(t3_flush_cnt), .done(t3_done)
  );

  logic       v7 [5];
  logic [6:0] i7 [5];
  logic       v3 [5];
  logic [2:0] i3 [5];
  assign v7 = '{if_valid, id_valid, ex_valid, mem_valid, wb_valid};
  assign i7 = '{if_id, id_id, ex_id, mem_id, wb_id};
  assign v3 = '{t3_if_valid, t3_id_valid, t3_ex_valid, t3_mem_valid, t3_wb_valid};
  assign i3 = '{t3_if_id, t3_id_id, t3_ex_id, t3_mem_id, t3_wb_id};

  string stg [5] = '{"if", "id", "ex", "mem", "wb"};

  // Reference model: each stage holds an instruction record (unbounded sequence number, pc).
  bit     m_v [5];
  int     m_s [5];
  int     m_p [5];
  int     m_next;
  int     m_state;
  longint m_cyc, m_ret, m_stl, m_fls;
  int     sb_q [$];

  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint sat32(input longint v);
    return (v > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : v;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 5; s++) begin
      m_v[s] = 0; m_s[s] = 0; m_p[s] = 0;
    end
    m_next = 0; m_state = 0;
    m_cyc = 0; m_ret = 0; m_stl = 0; m_fls = 0;
    sb_q.delete();
  endtask

  task automatic model_edge(input bit st, input bit fl, input bit ht, input logic [15:0] pc);
    bit empty;
    empty = !(m_v[0] || m_v[1] || m_v[2] || m_v[3] || m_v[4]);
    m_cyc = sat32(m_cyc + 1);
    if (m_v[4]) m_ret = sat32(m_ret + 1);
    if (st) m_stl = sat32(m_stl + 1);
    else if (fl) m_fls = sat32(m_fls + 1);
    for (int s = 4; s >= 3; s--) begin
      m_v[s] = m_v[s-1]; m_s[s] = m_s[s-1]; m_p[s] = m_p[s-1];
    end
    if (st) begin
      m_v[2] = 0; m_s[2] = 0; m_p[2] = 0;
    end else begin
      m_v[2] = m_v[1]; m_s[2] = m_s[1]; m_p[2] = m_p[1];
      if (fl) begin
        if (m_v[0]) void'(sb_q.pop_back());
        m_v[1] = 0; m_s[1] = 0; m_p[1] = 0;
      end else begin
        m_v[1] = m_v[0]; m_s[1] = m_s[0]; m_p[1] = m_p[0];
      end
      if (m_state == 0 && !(ht && !fl)) begin
        m_v[0] = 1; m_s[0] = m_next; m_p[0] = int'(pc);
        sb_q.push_back(m_next);
        m_next++;
      end else begin
        m_v[0] = 0; m_s[0] = 0; m_p[0] = 0;
      end
    end
    if (m_state == 0 && !st && ht && !fl) m_state = 1;
    else if (m_state == 1 && empty) m_state = 2;
  endtask

  task automatic compare_all();
    for (int s = 0; s < 5; s++) begin
      chk($sformatf("%s_valid", stg[s]), v7[s], m_v[s]);
      chk($sformatf("%s_id", stg[s]), i7[s], m_s[s] % 128);
      chk($sformatf("%s_valid_w3", stg[s]), v3[s], m_v[s]);
      chk($sformatf("%s_id_w3", stg[s]), i3[s], m_s[s] % 8);
    end
    chk("wb_pc", wb_pc, m_p[4]);
    chk("wb_pc_w3", t3_wb_pc, m_p[4]);
    chk("cycle_cnt", cycle_cnt, m_cyc);
    chk("retired_cnt", retired_cnt, m_ret);
    chk("stall_cnt", stall_cnt, m_stl);
    chk("flush_cnt", flush_cnt, m_fls);
    chk("done", done, m_state == 2);
    chk("counters_w3", {t3_cycle_cnt, t3_retired_cnt}, {m_cyc[31:0], m_ret[31:0]});
    chk("stall_flush_w3", {t3_stall_cnt, t3_flush_cnt}, {m_stl[31:0], m_fls[31:0]});
    chk("done_w3", t3_done, m_state == 2);
    if (wb_valid === 1'b1) begin
      if (sb_q.size() > 0) begin
        int e;
        e = sb_q.pop_front();
        chk("retire_order", wb_id, e % 128);
      end else begin
        chk("retire_extra", wb_valid, 0);
      end
    end
  endtask

  task automatic tick(input bit st, input bit fl, input bit ht, input logic [15:0] pc);
    pc_stall = st; if_flush = fl; halt_fetch = ht; fetch_pc = pc;
    @(posedge clk);
    model_edge(st, fl, ht, pc);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(1'b0, 1'b0, 1'b0, 16'($urandom_range(0, 65535)));
  endtask

  // Reset is dropped between edges and checked before any further clock edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    model_reset();
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit          st, fl, ht;
    logic [15:0] pc;
    bit          e_if_v;
    int          e_if_id;
    bit          e_wb_v;
    int          e_wb_id;
    logic [15:0] e_wb_pc;
    int          e_ret;
  } vec_t;

  vec_t vecs [10];

  initial begin
    vecs[0] = '{0, 0, 0, 16'h1000, 1, 0, 0, 0, 16'h0000, 0};
    vecs[1] = '{0, 0, 0, 16'h1004, 1, 1, 0, 0, 16'h0000, 0};
    vecs[2] = '{0, 0, 0, 16'h1008, 1, 2, 0, 0, 16'h0000, 0};
    vecs[3] = '{0, 0, 0, 16'h100C, 1, 3, 0, 0, 16'h0000, 0};
    vecs[4] = '{0, 0, 0, 16'h1010, 1, 4, 1, 0, 16'h1000, 0};
    vecs[5] = '{0, 0, 0, 16'h1014, 1, 5, 1, 1, 16'h1004, 1};
    vecs[6] = '{0, 0, 0, 16'h1018, 1, 6, 1, 2, 16'h1008, 2};
    vecs[7] = '{0, 0, 0, 16'h101C, 1, 7, 1, 3, 16'h100C, 3};
    vecs[8] = '{0, 0, 0, 16'h1020, 1, 8, 1, 4, 16'h1010, 4};
    vecs[9] = '{0, 0, 0, 16'h1024, 1, 9, 1, 5, 16'h1014, 5};

    #1;
    do_reset();

    for (int k = 0; k < 10; k++) begin
      tick(vecs[k].st, vecs[k].fl, vecs[k].ht, vecs[k].pc);
      chk($sformatf("tbl%0d_if_valid", k), if_valid, vecs[k].e_if_v);
      chk($sformatf("tbl%0d_if_id", k), if_id, vecs[k].e_if_id);
      chk($sformatf("tbl%0d_if_id_w3", k), t3_if_id, vecs[k].e_if_id % 8);
      chk($sformatf("tbl%0d_wb_valid", k), wb_valid, vecs[k].e_wb_v);
      chk($sformatf("tbl%0d_wb_id", k), wb_id, vecs[k].e_wb_id);
      chk($sformatf("tbl%0d_wb_pc", k), wb_pc, vecs[k].e_wb_pc);
      chk($sformatf("tbl%0d_retired", k), retired_cnt, vecs[k].e_ret);
    end

    // Mid-run asynchronous reset; do_reset checks everything cleared before the next edge.
    do_reset();

    // Single stall while ID holds ID 3.
    idle(5);
    chk("stall_pre_id", id_id, 3);
    tick(1'b1, 1'b0, 1'b0, 16'h3000);
    chk("stall_id_hold", id_id, 3);
    chk("stall_ex_bubble", ex_valid, 0);
    chk("stall_cnt", stall_cnt, 1);
    idle(1);
    chk("stall_ex_id", ex_id, 3);
    idle(1);
    chk("stall_wb_gap", wb_valid, 0);
    idle(1);
    chk("stall_late_retire", {wb_valid, wb_id}, {1'b1, 7'd3});

    // Flush while IF holds ID 5.
    do_reset();
    idle(6);
    chk("flush_pre_if", if_id, 5);
    tick(1'b0, 1'b1, 1'b0, 16'h4000);
    chk("flush_id_bubble", id_valid, 0);
    chk("flush_if_next", if_id, 6);
    chk("flush_cnt", flush_cnt, 1);
    idle(2);
    chk("flush_wb4", {wb_valid, wb_id}, {1'b1, 7'd4});
    idle(1);
    chk("flush_wb_gap", wb_valid, 0);
    idle(1);
    chk("flush_wb6", {wb_valid, wb_id}, {1'b1, 7'd6});

    // Stall and flush on the same edge behave as a stall.
    do_reset();
    idle(3);
    tick(1'b1, 1'b1, 1'b0, 16'h5000);
    chk("sf_flush_cnt", flush_cnt, 0);
    chk("sf_stall_cnt", stall_cnt, 1);
    chk("sf_id_kept", {id_valid, id_id}, {1'b1, 7'd1});
    chk("sf_if_kept", if_id, 2);
    idle(6);

    // HLT with ID 7 in IF.
    do_reset();
    idle(8);
    tick(1'b0, 1'b0, 1'b1, 16'h6000);
    chk("hlt_if_bubble", if_valid, 0);
    chk("hlt_id", id_id, 7);
    idle(3);
    chk("hlt_wb7", {wb_valid, wb_id}, {1'b1, 7'd7});
    idle(1);
    chk("hlt_not_done", done, 0);
    chk("hlt_retired_pre", retired_cnt, 8);
    idle(1);
    chk("hlt_done", done, 1);
    chk("hlt_retired", retired_cnt, 8);
    idle(3);
    chk("hlt_stays_done", {done, if_valid}, {1'b1, 1'b0});

    // Squashed HLT: flush alongside keeps fetching.
    do_reset();
    idle(8);
    tick(1'b0, 1'b1, 1'b1, 16'h7000);
    chk("sqhlt_if", {if_valid, if_id}, {1'b1, 7'd8});
    chk("sqhlt_id_bubble", id_valid, 0);
    idle(8);
    chk("sqhlt_not_done", done, 0);

    // Randomized segments against the model.
    for (int seg = 0; seg < 4; seg++) begin
      do_reset();
      for (int c = 0; c < (seg == 0 ? 300 : 150); c++) begin
        bit st, fl, ht;
        st = ($urandom_range(0, 99) < 15);
        fl = ($urandom_range(0, 99) < 15);
        ht = (seg != 0) && ($urandom_range(0, 99) < 3);
        tick(st, fl, ht, 16'($urandom_range(0, 65535)));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
